// File: rtl/pcie_8b10b_pkg.sv
// Shared 8b/10b encoding tables, running-disparity type and the neutrality helper
// used by the PCIe transmit-side line encoder.
package pcie_8b10b_pkg;

    typedef enum logic {
        RD_NEG = 1'b0,
        RD_POS = 1'b1
    } rd_e;

    // Each entry packs {RD- code, RD+ code}; abcdei with 'a' in the MSB.
    localparam logic [11:0] TBL_5B6B [32] = '{
        12'b100111_011000, 12'b011101_100010, 12'b101101_010010, 12'b110001_110001,
        12'b110101_001010, 12'b101001_101001, 12'b011001_011001, 12'b111000_000111,
        12'b111001_000110, 12'b100101_100101, 12'b010101_010101, 12'b110100_110100,
        12'b001101_001101, 12'b101100_101100, 12'b011100_011100, 12'b010111_101000,
        12'b011011_100100, 12'b100011_100011, 12'b010011_010011, 12'b110010_110010,
        12'b001011_001011, 12'b101010_101010, 12'b011010_011010, 12'b111010_000101,
        12'b110011_001100, 12'b100110_100110, 12'b010110_010110, 12'b110110_001001,
        12'b001110_001110, 12'b101110_010001, 12'b011110_100001, 12'b101011_010100
    };

    // Each entry packs {RD- code, RD+ code}; fghj. Entry 7 is the primary P7 code.
    localparam logic [7:0] TBL_3B4B [8] = '{
        8'b1011_0100, 8'b1001_1001, 8'b0101_0101, 8'b1100_0011,
        8'b1101_0010, 8'b1010_1010, 8'b0110_0110, 8'b1110_0001
    };

    localparam logic [7:0] A7_CODE = 8'b0111_1000;

    // A 4-bit code is checked by padding it with one 1 and one 0, which keeps its balance.
    function automatic logic is_neutral(input logic [5:0] code);
        logic [2:0] ones;
        ones = 3'd0;
        for (int i = 0; i < 6; i++) begin
            ones = ones + {2'b00, code[i]};
        end
        return (ones == 3'd3);
    endfunction

endpackage

// File: rtl/pcie_encoder_8b10b_lut.sv
// Purely combinational 8b/10b data-character encoder: 5b/6b lookup, intermediate
// disparity, then 3b/4b lookup with alternate x.7 selection.
module encoder_8b10b_lut
    import pcie_8b10b_pkg::*;
(
    input  logic [7:0] data_i,
    input  rd_e        rd_i,
    output logic [9:0] symbol_o,
    output rd_e        rd_o
);

    logic [4:0] x_s;
    logic [2:0] y_s;
    logic [5:0] code6_s;
    logic [7:0] pair4_s;
    logic [3:0] code4_s;
    logic       alt7_s;
    rd_e        rd_mid_s;

    // Full encode path: both sub-blocks resolved in the same cycle.
    always_comb begin
        x_s = data_i[4:0];
        y_s = data_i[7:5];

        if (rd_i == RD_NEG) begin
            code6_s = TBL_5B6B[x_s][11:6];
        end else begin
            code6_s = TBL_5B6B[x_s][5:0];
        end

        if (is_neutral(code6_s)) begin
            rd_mid_s = rd_i;
        end else if (rd_i == RD_NEG) begin
            rd_mid_s = RD_POS;
        end else begin
            rd_mid_s = RD_NEG;
        end

        // A7 avoids a run of five identical bits across the sub-block boundary.
        if (rd_mid_s == RD_NEG) begin
            alt7_s = (x_s == 5'd17) || (x_s == 5'd18) || (x_s == 5'd20);
        end else begin
            alt7_s = (x_s == 5'd11) || (x_s == 5'd13) || (x_s == 5'd14);
        end

        if ((y_s == 3'd7) && alt7_s) begin
            pair4_s = A7_CODE;
        end else begin
            pair4_s = TBL_3B4B[y_s];
        end

        if (rd_mid_s == RD_NEG) begin
            code4_s = pair4_s[7:4];
        end else begin
            code4_s = pair4_s[3:0];
        end

        if (is_neutral({2'b10, code4_s})) begin
            rd_o = rd_mid_s;
        end else if (rd_mid_s == RD_NEG) begin
            rd_o = RD_POS;
        end else begin
            rd_o = RD_NEG;
        end

        symbol_o = {code6_s, code4_s};
    end

endmodule

// File: rtl/pcie_encoder_8b10b.sv
// Registered 8b/10b line encoder: one byte per clock, symbol out one cycle later,
// running disparity carried from symbol to symbol.
module pcie_encoder_8b10b
    import pcie_8b10b_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_i,
    output logic [9:0] symbol_o
);

    logic [9:0] symbol_d;
    logic [9:0] symbol_q;
    rd_e        rd_d;
    rd_e        rd_q;

    encoder_8b10b_lut u_lut (
        .data_i   (data_i),
        .rd_i     (rd_q),
        .symbol_o (symbol_d),
        .rd_o     (rd_d)
    );

    // Symbol and disparity advance together; reset drops any residual disparity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            symbol_q <= 10'h000;
            rd_q     <= RD_NEG;
        end else begin
            symbol_q <= symbol_d;
            rd_q     <= rd_d;
        end
    end

    assign symbol_o = symbol_q;

endmodule

// File: tb/tb_pcie_encoder_8b10b.sv
// Self-checking bench for pcie_encoder_8b10b: independent reference model with a
// scoreboard queue, directed vector table, async-reset sequence and exhaustive sweep.
module tb_pcie_encoder_8b10b;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic [9:0] symbol_o;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_q [$];
    logic       m_rd;
    int         run_sum;
    int         run_len;
    logic       last_bit;
    logic       have_last;

    logic [5:0] m6 [32];
    logic [3:0] m4 [8];

    typedef struct {
        logic [7:0] data;
        logic       rd_in;
        logic [9:0] sym;
        logic       rd_out;
    } vec_t;

    vec_t vecs [10];

    pcie_encoder_8b10b dut (
        .clk      (clk),
        .reset    (reset),
        .data_i   (data_i),
        .symbol_o (symbol_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    // Reference built from RD- codes only; RD+ codes are complements of unbalanced codes.
    function automatic logic [10:0] model(input logic [7:0] b, input logic rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       n;
        logic       alt;
        logic       r;
        r  = rd_in;
        x  = b[4:0];
        y  = b[7:5];
        c6 = m6[x];
        n  = ($countones(c6) == 3);
        if (r && (!n || x == 5'd7)) c6 = ~c6;
        if (!n) r = ~r;
        if (y == 3'd7) begin
            if (r) alt = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
            else   alt = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
            c4 = alt ? 4'b0111 : 4'b1110;
        end else begin
            c4 = m4[y];
        end
        n = ($countones(c4) == 2);
        if (r && (!n || y == 3'd3 || y == 3'd7)) c4 = ~c4;
        if (!n) r = ~r;
        return {r, c6, c4};
    endfunction

    task automatic stream_check(input logic [9:0] s);
        int ones;
        int max_run;
        ones = $countones(s);
        check("weight_4_to_6", int'(ones >= 4 && ones <= 6), 1);
        run_sum = run_sum + 2 * ones - 10;
        check("running_sum", run_sum, m_rd ? 1 : -1);
        max_run = 0;
        for (int i = 9; i >= 0; i--) begin
            if (have_last && s[i] == last_bit) run_len++;
            else run_len = 1;
            last_bit  = s[i];
            have_last = 1'b1;
            if (run_len > max_run) max_run = run_len;
        end
        check("run_len_le5", int'(max_run <= 5), 1);
    endtask

    task automatic send(input logic [7:0] b, input string name);
        logic [10:0] r;
        logic [9:0]  e;
        logic [9:0]  act;
        r    = model(b, m_rd);
        m_rd = r[10];
        exp_q.push_back(r[9:0]);
        data_i = b;
        @(posedge clk);
        #1;
        act = symbol_o;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
        stream_check(act);
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_rd      = 1'b0;
        run_sum   = -1;
        run_len   = 0;
        have_last = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        data_i = 8'h01;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_symbol", symbol_o, 0);
        end
        reset = 1'b0;
        clear_model();
    endtask

    task automatic set_rd(input logic target);
        if (m_rd != target) send(8'h20, "rd_prep");
    endtask

    initial begin
        m6 = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
               6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
               6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
               6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
        m4 = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

        vecs[0] = '{8'h01, 1'b0, 10'h1D4, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 10'h274, 1'b0};
        vecs[2] = '{8'h20, 1'b0, 10'h279, 1'b1};
        vecs[3] = '{8'h20, 1'b1, 10'h189, 1'b0};
        vecs[4] = '{8'hF1, 1'b0, 10'h237, 1'b1};
        vecs[5] = '{8'hEB, 1'b1, 10'h348, 1'b0};
        vecs[6] = '{8'h63, 1'b0, 10'h31C, 1'b0};
        vecs[7] = '{8'hE7, 1'b0, 10'h38E, 1'b1};
        vecs[8] = '{8'hF4, 1'b1, 10'h0B1, 1'b0};
        vecs[9] = '{8'hB7, 1'b1, 10'h05A, 1'b0};

        clear_model();

        // Held D1.0, D0.0 and D0.1 streams from reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(8'h01, "d1_0_hold");
            check("d1_0_const", symbol_o, 10'h1D4);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(8'h00, "d0_0_hold");
            check("d0_0_const", symbol_o, 10'h274);
        end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(8'h20, "d0_1_alt");
            check("d0_1_const", symbol_o, (i % 2 == 0) ? 10'h279 : 10'h189);
        end

        // Directed vector table; the following D0.1 reveals the disparity left behind.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            set_rd(vecs[v].rd_in);
            send(vecs[v].data, "vec_model");
            check("vec_const", symbol_o, vecs[v].sym);
            send(8'h20, "vec_probe");
            check("vec_rd_out", symbol_o, vecs[v].rd_out ? 10'h189 : 10'h279);
        end

        // Back-to-back A7 selection from reset.
        do_reset();
        send(8'hF1, "a7_d17_7");
        check("a7_d17_7_const", symbol_o, 10'h237);
        send(8'hEB, "a7_d11_7");
        check("a7_d11_7_const", symbol_o, 10'h348);

        // Asynchronous reset while RD+ clears output before the next edge.
        do_reset();
        send(8'h20, "pre_async");
        #2;
        reset = 1'b1;
        #1;
        check("async_clear", symbol_o, 0);
        @(posedge clk);
        #1;
        check("async_hold", symbol_o, 0);
        reset = 1'b0;
        clear_model();
        send(8'h20, "post_async");
        check("post_async_const", symbol_o, 10'h279);

        // Every byte from both disparity states.
        do_reset();
        for (int t = 0; t < 2; t++) begin
            for (int b = 0; b < 256; b++) begin
                set_rd(t[0]);
                send(b[7:0], "exhaustive");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
